// File: rtl/hash_lookup_sched.sv
// Scheduler for a three-table hash lookup pipeline: arbitrates lookups and updates,
// bounds the number of lookups in flight, and sweeps all tables to empty on request.
module hash_lookup_sched #(
    parameter int ADDR_W  = 12,
    parameter int MAX_OUT = 8
) (
    input  logic                  Sys_clk,
    input  logic                  Rst,
    input  logic [3*ADDR_W-1:0]   Lkp_addr,
    input  logic                  Lkp_wr,
    output logic                  Lkp_ready,
    input  logic [ADDR_W-1:0]     Upd_addr,
    input  logic [1:0]            Upd_sel,
    input  logic [3:0]            Upd_data,
    input  logic                  Upd_wr,
    output logic                  Upd_ready,
    input  logic                  Clr_req,
    output logic                  Clr_done,
    output logic                  Busy,
    input  logic                  Res_wr,
    output logic [ADDR_W-1:0]     Hash_addr1,
    output logic [ADDR_W-1:0]     Hash_addr2,
    output logic [ADDR_W-1:0]     Hash_addr3,
    output logic                  Hash_rd,
    output logic [2:0]            Hash_we,
    output logic [3:0]            Hash_wdata,
    output logic                  Err_uflow
);

    typedef enum logic [1:0] {
        SERVE = 2'd0,
        DRAIN = 2'd1,
        CLEAR = 2'd2,
        DONE  = 2'd3
    } state_t;

    typedef enum logic {
        RR_LKP = 1'b0,
        RR_UPD = 1'b1
    } rr_t;

    localparam int                CNT_W     = 4;
    localparam logic [CNT_W-1:0]  CNT_MAX   = CNT_W'(MAX_OUT);
    localparam logic [ADDR_W-1:0] ADDR_LAST = {ADDR_W{1'b1}};
    localparam logic [ADDR_W-1:0] ADDR_ZERO = {ADDR_W{1'b0}};
    localparam logic [3:0]        EMPTY_VAL = 4'hF;

    state_t             state_q, state_d;
    rr_t                rr_q, rr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [ADDR_W-1:0]  clr_addr_q, clr_addr_d;
    logic               err_uflow_q, err_uflow_d;
    logic [ADDR_W-1:0]  hash_addr1_q, hash_addr1_d;
    logic [ADDR_W-1:0]  hash_addr2_q, hash_addr2_d;
    logic [ADDR_W-1:0]  hash_addr3_q, hash_addr3_d;
    logic               hash_rd_q, hash_rd_d;
    logic [2:0]         hash_we_q, hash_we_d;
    logic [3:0]         hash_wdata_q, hash_wdata_d;

    logic serve_s, lkp_ok_s, lkp_ready_s, upd_ready_s, lkp_go_s, upd_go_s;

    // Grants are exclusive: when both requests compete, rr_q decides.
    assign serve_s     = (state_q == SERVE) && !Clr_req && !Rst;
    assign lkp_ok_s    = serve_s && (cnt_q < CNT_MAX);
    assign lkp_ready_s = lkp_ok_s && (!Upd_wr || (rr_q == RR_LKP));
    assign upd_ready_s = serve_s && (!Lkp_wr || !lkp_ok_s || (rr_q == RR_UPD));
    assign lkp_go_s    = Lkp_wr && lkp_ready_s;
    assign upd_go_s    = Upd_wr && upd_ready_s;

    // In-flight counter and sticky underflow flag.
    always_comb begin
        cnt_d       = cnt_q;
        err_uflow_d = err_uflow_q;
        if (lkp_go_s && !Res_wr) begin
            cnt_d = cnt_q + 4'd1;
        end else if (Res_wr && !lkp_go_s) begin
            if (cnt_q == 4'd0) begin
                err_uflow_d = 1'b1;
            end else begin
                cnt_d = cnt_q - 4'd1;
            end
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Round-robin pointer favours the side that was not granted last.
    always_comb begin
        rr_d = rr_q;
        if (lkp_go_s) begin
            rr_d = RR_UPD;
        end else if (upd_go_s) begin
            rr_d = RR_LKP;
        end else begin
            rr_d = rr_q;
        end
    end

    // Next state and next registered table-port values; idle cycles drive zeros.
    always_comb begin
        state_d      = state_q;
        clr_addr_d   = clr_addr_q;
        hash_addr1_d = ADDR_ZERO;
        hash_addr2_d = ADDR_ZERO;
        hash_addr3_d = ADDR_ZERO;
        hash_rd_d    = 1'b0;
        hash_we_d    = 3'b000;
        hash_wdata_d = 4'h0;
        case (state_q)
            SERVE: begin
                if (Clr_req) begin
                    state_d = DRAIN;
                end else if (lkp_go_s) begin
                    hash_rd_d    = 1'b1;
                    hash_addr1_d = Lkp_addr[ADDR_W-1:0];
                    hash_addr2_d = Lkp_addr[2*ADDR_W-1:ADDR_W];
                    hash_addr3_d = Lkp_addr[3*ADDR_W-1:2*ADDR_W];
                end else if (upd_go_s) begin
                    case (Upd_sel)
                        2'd1: begin
                            hash_we_d    = 3'b001;
                            hash_addr1_d = Upd_addr;
                            hash_wdata_d = Upd_data;
                        end
                        2'd2: begin
                            hash_we_d    = 3'b010;
                            hash_addr2_d = Upd_addr;
                            hash_wdata_d = Upd_data;
                        end
                        2'd3: begin
                            hash_we_d    = 3'b100;
                            hash_addr3_d = Upd_addr;
                            hash_wdata_d = Upd_data;
                        end
                        default: begin
                            hash_we_d = 3'b000;
                        end
                    endcase
                end else begin
                    state_d = SERVE;
                end
            end
            DRAIN: begin
                // The first clear write is launched here so it lands in the first CLEAR cycle.
                if (cnt_q == 4'd0) begin
                    state_d      = CLEAR;
                    clr_addr_d   = ADDR_ZERO;
                    hash_we_d    = 3'b111;
                    hash_wdata_d = EMPTY_VAL;
                end else begin
                    state_d = DRAIN;
                end
            end
            CLEAR: begin
                if (clr_addr_q == ADDR_LAST) begin
                    state_d = DONE;
                end else begin
                    clr_addr_d   = clr_addr_q + ADDR_W'(1);
                    hash_we_d    = 3'b111;
                    hash_addr1_d = clr_addr_d;
                    hash_addr2_d = clr_addr_d;
                    hash_addr3_d = clr_addr_d;
                    hash_wdata_d = EMPTY_VAL;
                end
            end
            DONE: begin
                state_d    = SERVE;
                clr_addr_d = ADDR_ZERO;
            end
            default: begin
                state_d    = SERVE;
                clr_addr_d = ADDR_ZERO;
            end
        endcase
    end

    // State, counters and registered table-port outputs.
    always_ff @(posedge Sys_clk or posedge Rst) begin
        if (Rst) begin
            state_q      <= SERVE;
            rr_q         <= RR_LKP;
            cnt_q        <= 4'd0;
            clr_addr_q   <= ADDR_ZERO;
            err_uflow_q  <= 1'b0;
            hash_addr1_q <= ADDR_ZERO;
            hash_addr2_q <= ADDR_ZERO;
            hash_addr3_q <= ADDR_ZERO;
            hash_rd_q    <= 1'b0;
            hash_we_q    <= 3'b000;
            hash_wdata_q <= 4'h0;
        end else begin
            state_q      <= state_d;
            rr_q         <= rr_d;
            cnt_q        <= cnt_d;
            clr_addr_q   <= clr_addr_d;
            err_uflow_q  <= err_uflow_d;
            hash_addr1_q <= hash_addr1_d;
            hash_addr2_q <= hash_addr2_d;
            hash_addr3_q <= hash_addr3_d;
            hash_rd_q    <= hash_rd_d;
            hash_we_q    <= hash_we_d;
            hash_wdata_q <= hash_wdata_d;
        end
    end

    assign Lkp_ready  = lkp_ready_s;
    assign Upd_ready  = upd_ready_s;
    assign Busy       = (state_q != SERVE);
    assign Clr_done   = (state_q == DONE);
    assign Err_uflow  = err_uflow_q;
    assign Hash_addr1 = hash_addr1_q;
    assign Hash_addr2 = hash_addr2_q;
    assign Hash_addr3 = hash_addr3_q;
    assign Hash_rd    = hash_rd_q;
    assign Hash_we    = hash_we_q;
    assign Hash_wdata = hash_wdata_q;

endmodule

// File: tb/tb_hash_lookup_sched.sv
// Directed bench for hash_lookup_sched: expected table-port activity is queued when a
// request is driven and compared one cycle later against the registered outputs.
module tb_hash_lookup_sched;

    localparam int AW = 12;

    logic            Sys_clk = 1'b0;
    logic            Rst;
    logic [3*AW-1:0] Lkp_addr;
    logic            Lkp_wr;
    logic            Lkp_ready;
    logic [AW-1:0]   Upd_addr;
    logic [1:0]      Upd_sel;
    logic [3:0]      Upd_data;
    logic            Upd_wr;
    logic            Upd_ready;
    logic            Clr_req;
    logic            Clr_done;
    logic            Busy;
    logic            Res_wr;
    logic [AW-1:0]   Hash_addr1, Hash_addr2, Hash_addr3;
    logic            Hash_rd;
    logic [2:0]      Hash_we;
    logic [3:0]      Hash_wdata;
    logic            Err_uflow;

    typedef struct packed {
        logic          rd;
        logic [2:0]    we;
        logic [AW-1:0] a1;
        logic [AW-1:0] a2;
        logic [AW-1:0] a3;
        logic [3:0]    wd;
    } iss_t;

    iss_t exp_q[$];
    iss_t obs_s;
    int   n_checks = 0;
    int   n_err    = 0;

    always #4 Sys_clk = ~Sys_clk;

    assign obs_s = {Hash_rd, Hash_we, Hash_addr1, Hash_addr2, Hash_addr3, Hash_wdata};

    hash_lookup_sched #(.ADDR_W(AW), .MAX_OUT(8)) dut (
        .Sys_clk(Sys_clk), .Rst(Rst),
        .Lkp_addr(Lkp_addr), .Lkp_wr(Lkp_wr), .Lkp_ready(Lkp_ready),
        .Upd_addr(Upd_addr), .Upd_sel(Upd_sel), .Upd_data(Upd_data),
        .Upd_wr(Upd_wr), .Upd_ready(Upd_ready),
        .Clr_req(Clr_req), .Clr_done(Clr_done), .Busy(Busy), .Res_wr(Res_wr),
        .Hash_addr1(Hash_addr1), .Hash_addr2(Hash_addr2), .Hash_addr3(Hash_addr3),
        .Hash_rd(Hash_rd), .Hash_we(Hash_we), .Hash_wdata(Hash_wdata),
        .Err_uflow(Err_uflow)
    );

    function automatic iss_t lkp_rec(input int a1, input int a2, input int a3);
        iss_t r = '0;
        r.rd = 1'b1;
        r.a1 = AW'(a1);
        r.a2 = AW'(a2);
        r.a3 = AW'(a3);
        return r;
    endfunction

    function automatic iss_t upd_rec(input logic [1:0] sel, input logic [AW-1:0] a, input logic [3:0] d);
        iss_t r = '0;
        case (sel)
            2'd1: begin r.we = 3'b001; r.a1 = a; r.wd = d; end
            2'd2: begin r.we = 3'b010; r.a2 = a; r.wd = d; end
            2'd3: begin r.we = 3'b100; r.a3 = a; r.wd = d; end
            default: r = '0;
        endcase
        return r;
    endfunction

    function automatic iss_t clr_rec(input int a);
        iss_t r;
        r.rd = 1'b0;
        r.we = 3'b111;
        r.a1 = AW'(a);
        r.a2 = AW'(a);
        r.a3 = AW'(a);
        r.wd = 4'hF;
        return r;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called at posedge+1 with inputs already driven; checks readies, then the issue one edge later.
    task automatic cyc(input logic exp_lr, input logic exp_ur, input iss_t exp_iss, input string tag);
        iss_t e;
        #1;
        chk({tag, ":lkp_ready"}, 64'(Lkp_ready), 64'(exp_lr));
        chk({tag, ":upd_ready"}, 64'(Upd_ready), 64'(exp_ur));
        exp_q.push_back(exp_iss);
        @(posedge Sys_clk);
        #1;
        e = exp_q.pop_front();
        chk({tag, ":issue"}, 64'(obs_s), 64'(e));
    endtask

    task automatic idle_inputs();
        Lkp_addr = '0; Lkp_wr = 1'b0; Upd_addr = '0; Upd_sel = 2'd0; Upd_data = 4'h0;
        Upd_wr = 1'b0; Clr_req = 1'b0; Res_wr = 1'b0;
    endtask

    task automatic do_reset();
        Rst = 1'b1;
        idle_inputs();
        @(posedge Sys_clk);
        #1;
        chk("rst:hash", 64'(obs_s), 64'd0);
        chk("rst:ctl", 64'({Lkp_ready, Upd_ready, Busy, Clr_done, Err_uflow}), 64'd0);
        @(posedge Sys_clk);
        #1;
        Rst = 1'b0;
    endtask

    initial begin
        Rst = 1'b1;
        idle_inputs();
        do_reset();

        // Single lookup, then its result returns.
        Lkp_addr = {12'h003, 12'h002, 12'h001}; Lkp_wr = 1'b1;
        cyc(1'b1, 1'b0, lkp_rec(1, 2, 3), "lkp1");
        Lkp_wr = 1'b0; Res_wr = 1'b1;
        cyc(1'b1, 1'b1, '0, "lkp1_res");
        Res_wr = 1'b0;

        // Both requesting: alternation until the in-flight limit, then updates only.
        do_reset();
        Lkp_wr = 1'b1; Upd_wr = 1'b1;
        for (int i = 0; i < 16; i++) begin
            Lkp_addr = {12'(i + 3), 12'(i + 2), 12'(i + 1)};
            Upd_sel  = 2'(i % 3 + 1);
            Upd_addr = 12'(i * 5);
            Upd_data = 4'(i);
            if (i % 2 == 0) cyc(1'b1, 1'b0, lkp_rec(i + 1, i + 2, i + 3), "alt_lkp");
            else            cyc(1'b0, 1'b1, upd_rec(Upd_sel, Upd_addr, Upd_data), "alt_upd");
        end
        for (int i = 0; i < 3; i++) begin
            Upd_sel = 2'd3; Upd_addr = 12'(100 + i); Upd_data = 4'(9 + i);
            cyc(1'b0, 1'b1, upd_rec(Upd_sel, Upd_addr, Upd_data), "full_upd");
        end
        Upd_wr = 1'b0;
        Lkp_addr = {12'h0C3, 12'h0C2, 12'h0C1};
        cyc(1'b0, 1'b1, '0, "full_pend");
        Res_wr = 1'b1;
        cyc(1'b0, 1'b1, '0, "full_res");
        Res_wr = 1'b0;
        cyc(1'b1, 1'b0, lkp_rec(12'h0C1, 12'h0C2, 12'h0C3), "ninth_lkp");
        Lkp_wr = 1'b0;

        // Update to table 2, then a no-op update.
        do_reset();
        Upd_wr = 1'b1; Upd_sel = 2'd2; Upd_addr = 12'h0AB; Upd_data = 4'd5;
        cyc(1'b1, 1'b1, upd_rec(2'd2, 12'h0AB, 4'd5), "upd_t2");
        Upd_sel = 2'd0;
        cyc(1'b1, 1'b1, '0, "upd_noop");
        Upd_wr = 1'b0;
        cyc(1'b1, 1'b1, '0, "upd_idle");

        // Clear with two lookups outstanding.
        Lkp_wr = 1'b1; Lkp_addr = {12'h013, 12'h012, 12'h011};
        cyc(1'b1, 1'b0, lkp_rec(12'h011, 12'h012, 12'h013), "clr_lkpa");
        Lkp_addr = {12'h023, 12'h022, 12'h021};
        cyc(1'b1, 1'b1, lkp_rec(12'h021, 12'h022, 12'h023), "clr_lkpb");
        Lkp_wr = 1'b0; Clr_req = 1'b1;
        cyc(1'b0, 1'b0, '0, "clr_req");
        Clr_req = 1'b0; Lkp_wr = 1'b1; Upd_wr = 1'b1; Upd_sel = 2'd3; Upd_data = 4'd7;
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, '0, "drain_hold");
        chk("drain_busy", 64'(Busy), 64'd1);
        Res_wr = 1'b1;
        cyc(1'b0, 1'b0, '0, "drain_res1");
        cyc(1'b0, 1'b0, '0, "drain_res2");
        Res_wr = 1'b0; Lkp_wr = 1'b0; Upd_wr = 1'b0;
        for (int a = 0; a < 4096; a++) begin
            cyc(1'b0, 1'b0, clr_rec(a), "clear");
            if (a == 100) chk("clear_busy", 64'({Busy, Clr_done}), 64'b10);
        end
        cyc(1'b0, 1'b0, '0, "clear_end");
        chk("clr_done_pulse", 64'({Busy, Clr_done}), 64'b11);
        cyc(1'b0, 1'b0, '0, "done");
        chk("after_done", 64'({Busy, Clr_done}), 64'b00);

        // Reset in the middle of a clear sweep.
        Clr_req = 1'b1;
        cyc(1'b0, 1'b0, '0, "clr2_req");
        Clr_req = 1'b0;
        for (int a = 0; a <= 100; a++) cyc(1'b0, 1'b0, clr_rec(a), "clear2");
        Rst = 1'b1;
        #1;
        chk("midclr_rst_hash", 64'(obs_s), 64'd0);
        chk("midclr_rst_ctl", 64'({Lkp_ready, Upd_ready, Busy, Clr_done, Err_uflow}), 64'd0);
        @(posedge Sys_clk);
        #1;
        chk("midclr_rst_hold", 64'({obs_s, Busy, Clr_done}), 64'd0);
        Rst = 1'b0;
        Lkp_wr = 1'b1; Lkp_addr = {12'h007, 12'h006, 12'h005};
        cyc(1'b1, 1'b0, lkp_rec(5, 6, 7), "post_rst_lkp");
        chk("post_rst_nodone", 64'({Busy, Clr_done}), 64'd0);
        Lkp_wr = 1'b0; Res_wr = 1'b1;
        cyc(1'b1, 1'b1, '0, "uf_res1");
        chk("uflow_clear", 64'({Err_uflow, Clr_done}), 64'd0);
        cyc(1'b1, 1'b1, '0, "uf_res2");
        chk("uflow_set", 64'(Err_uflow), 64'd1);
        Res_wr = 1'b0;
        cyc(1'b1, 1'b1, '0, "uf_idle");
        chk("uflow_sticky", 64'({Err_uflow, Clr_done}), 64'b10);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule

// File: doc/hash_lookup_sched.md
HASH_LOOKUP_SCHED -- requirements
Module: hash_lookup_sched

Interface
REQ-001 SHALL have parameter ADDR_W, default 12: hash table address width.
REQ-002 SHALL have parameter MAX_OUT, default 8: maximum number of lookups in flight (1..15).
REQ-003 SHALL have port Sys_clk  in  1  system clock, 125 MHz; the only clock.
REQ-004 SHALL have port Rst  in  1  reset; asynchronous, active-high.
REQ-005 SHALL have port Lkp_addr  in  3*ADDR_W  lookup indices {table3, table2, table1}.
REQ-006 SHALL have port Lkp_wr  in  1  lookup request valid.
REQ-007 SHALL have port Lkp_ready  out  1  lookup accepted when Lkp_wr && Lkp_ready.
REQ-008 SHALL have port Upd_addr  in  ADDR_W  update index.
REQ-009 SHALL have port Upd_sel  in  2  target table: 1/2/3; 0 = no-op.
REQ-010 SHALL have port Upd_data  in  4  value to write.
REQ-011 SHALL have port Upd_wr  in  1  update request valid.
REQ-012 SHALL have port Upd_ready  out  1  update accepted when Upd_wr && Upd_ready.
REQ-013 SHALL have port Clr_req  in  1  request to clear all tables to 4'hF (empty).
REQ-014 SHALL have port Clr_done  out  1  one-cycle pulse when a clear completes.
REQ-015 SHALL have port Busy  out  1  high while draining or clearing.
REQ-016 SHALL have port Res_wr  in  1  lookup result returned (from result selector enable).
REQ-017 SHALL have ports Hash_addr1, Hash_addr2, Hash_addr3  out  ADDR_W each  per-table address.
REQ-018 SHALL have port Hash_rd  out  1  read strobe to all three tables.
REQ-019 SHALL have port Hash_we  out  3  per-table write enable, bit0 = table1.
REQ-020 SHALL have port Hash_wdata  out  4  write data, shared.
REQ-021 SHALL have port Err_uflow  out  1  sticky: Res_wr arrived with zero lookups in flight.

Function
REQ-022 SHALL implement FSM SERVE, DRAIN, CLEAR, DONE.
REQ-023 SHALL hold an in-flight counter cnt: +1 on lookup accept, -1 on Res_wr, unchanged when both occur in one cycle; Res_wr at cnt==0 leaves cnt at 0 and sets Err_uflow.
REQ-024 SHALL define serve = (state==SERVE) && !Clr_req, and lkp_ok = serve && cnt<MAX_OUT.
REQ-025 SHALL drive Lkp_ready = lkp_ok && (!Upd_wr || rr==LKP) and Upd_ready = serve && (!Lkp_wr || !lkp_ok || rr==UPD), combinationally; the two grants SHALL never both occur.
REQ-026 SHALL set round-robin pointer rr to UPD after a lookup grant and to LKP after an update grant; otherwise rr is held.
REQ-027 SHALL issue an accepted lookup on the next cycle, for exactly one cycle: Hash_rd=1, Hash_addrN = Lkp_addr slice N, Hash_we=0.
REQ-028 SHALL issue an accepted update on the next cycle, for one cycle: Hash_we one-hot per Upd_sel, selected Hash_addrN=Upd_addr, Hash_wdata=Upd_data; Upd_sel==0 SHALL be accepted with Hash_we=0.
REQ-029 SHALL drive all Hash_addr, Hash_wdata, Hash_rd and Hash_we to 0 in cycles with no issue; all Hash_* outputs SHALL be registered.
REQ-030 SHALL move SERVE->DRAIN when Clr_req=1 in SERVE; Clr_req SHALL be ignored in other states.
REQ-031 SHALL move DRAIN->CLEAR when cnt==0; Res_wr SHALL keep decrementing cnt during DRAIN.
REQ-032 SHALL, in CLEAR, write addresses 0..2^ADDR_W-1 ascending, one per cycle: Hash_we=3'b111, all Hash_addrN=address, Hash_wdata=4'hF.
REQ-033 SHALL, after the write to address 2^ADDR_W-1, enter DONE for one cycle with Clr_done=1, then return to SERVE.
REQ-034 SHALL hold Busy=1 in DRAIN, CLEAR and DONE; readies SHALL be 0 in those states.

Reset
REQ-035 SHALL, on Rst=1 at any time including mid-clear, immediately force: state=SERVE, cnt=0, rr=LKP, clear address=0, Err_uflow=0, and all outputs 0; no Clr_done pulse SHALL follow.
REQ-036 SHALL accept requests from the first cycle after Rst deasserts.

Verification
REQ-037 SHALL cover: reset, then Lkp_addr={12'h003,12'h002,12'h001} with Lkp_wr for 1 cycle -> next cycle Hash_rd=1, Hash_addr1/2/3=1/2/3; cnt=1.
REQ-038 SHALL cover: 8 lookups with no Res_wr -> Lkp_ready=0 with a 9th request pending; one Res_wr -> Lkp_ready=1 in the following cycle.
REQ-039 SHALL cover: Lkp_wr and Upd_wr held high after reset -> grants alternate lookup, update, lookup, ...; with cnt==MAX_OUT, every grant goes to the update.
REQ-040 SHALL cover: Upd_sel=2, Upd_addr=12'h0AB, Upd_data=5 -> one cycle Hash_we=3'b010, Hash_addr2=12'h0AB, Hash_wdata=5; then Upd_sel=0 -> accepted, Hash_we=0.
REQ-041 SHALL cover: Clr_req with 2 lookups in flight -> readies 0 and no writes until 2 Res_wr; then 4096 cycles of Hash_we=3'b111, data 4'hF, addresses 0..4095; Clr_done for 1 cycle; Busy low afterwards.
REQ-042 SHALL cover: Rst asserted at clear address 100 -> all outputs 0 immediately, no Clr_done; a lookup after release issues normally; also Res_wr at cnt==0 -> Err_uflow=1.
